// File: rtl/display_scan.sv
// display_scan: multiplexed 7-segment scanner with per-digit blanking, dp, PWM brightness and frame strobe
// Optional: define DISPLAY_LAMP_TEST_EN to add lamp_test (forces all segments on, full brightness).
// Ports:
//   clk_sys, rst          clock, asynchronous active-high reset
//   data[DIGITS*4]        hex nibble per digit (digit i = data[4i+3:4i])
//   dp[DIGITS], blank     decimal point / dark flag per digit
//   bright[4]             brightness 0..15 (on for bright of 16 sub-ticks)
//   dig[DIGITS], seg[8]   registered digit enables and segments a..g,dp
//   frame                 one-cycle pulse at start of digit-0 slot
module display_scan #(
    parameter int DIGITS      = 8,
    parameter int CLK_HZ      = 50_000_000,
    parameter int SCAN_HZ     = 1000,
    parameter bit DIG_ACT_LOW = 1'b1,
    parameter bit SEG_ACT_LOW = 1'b1
) (
    input  logic                clk_sys,
    input  logic                rst,
    input  logic [DIGITS*4-1:0] data,
    input  logic [DIGITS-1:0]   dp,
    input  logic [DIGITS-1:0]   blank,
    input  logic [3:0]          bright,
`ifdef DISPLAY_LAMP_TEST_EN
    input  logic                lamp_test,
`endif
    output logic [DIGITS-1:0]   dig,
    output logic [7:0]          seg,
    output logic                frame
);
    localparam int TICKS = CLK_HZ / (SCAN_HZ * DIGITS * 16);
    localparam int PW = TICKS > 1 ? $clog2(TICKS) : 1;
    localparam int IW = DIGITS > 1 ? $clog2(DIGITS) : 1;
    localparam logic [DIGITS-1:0] DIG_OFF = DIG_ACT_LOW ? {DIGITS{1'b1}} : {DIGITS{1'b0}};
    localparam logic [7:0] SEG_OFF = SEG_ACT_LOW ? 8'hFF : 8'h00;
    // Active-high a..g patterns, nibble 0 in the low 7 bits.
    localparam logic [111:0] FONT = {7'h71, 7'h79, 7'h5E, 7'h39, 7'h7C, 7'h77, 7'h6F, 7'h7F,
                                     7'h07, 7'h7D, 7'h6D, 7'h66, 7'h4F, 7'h5B, 7'h06, 7'h3F};

    if (TICKS < 1) begin : g_ticks_chk
        $error("display_scan: CLK_HZ too low for SCAN_HZ*DIGITS*16");
    end

    logic [PW-1:0]     pre_q, pre_d;
    logic [3:0]        sub_q, sub_d;
    logic [IW-1:0]     idx_q, idx_d;
    logic [7:0]        snap_seg_q, snap_seg_d;
    logic              snap_blank_q, snap_blank_d;
    logic [3:0]        snap_bright_q, snap_bright_d;
    logic [DIGITS-1:0] dig_q, dig_d;
    logic [7:0]        seg_q, seg_d;
    logic              frame_q, frame_d;
    logic              tick, start, lit;
    logic [3:0]        nib;
    logic [7:0]        live_seg;
    logic              live_blank;
    logic [3:0]        live_bright;

    always_comb begin
        tick  = pre_q == PW'(TICKS - 1);
        start = pre_q == '0 && sub_q == 4'd0;
        pre_d = tick ? '0 : pre_q + 1'b1;
        sub_d = tick ? sub_q + 1'b1 : sub_q;
        idx_d = (tick && sub_q == 4'hF) ? (idx_q == IW'(DIGITS - 1) ? '0 : idx_q + 1'b1) : idx_q;
        nib   = data[{idx_q, 2'b00} +: 4];
`ifdef DISPLAY_LAMP_TEST_EN
        live_seg    = lamp_test ? 8'hFF : {dp[idx_q], FONT[nib*7 +: 7]};
        live_blank  = !lamp_test && blank[idx_q];
        live_bright = lamp_test ? 4'hF : bright;
`else
        live_seg    = {dp[idx_q], FONT[nib*7 +: 7]};
        live_blank  = blank[idx_q];
        live_bright = bright;
`endif
        snap_seg_d    = start ? live_seg : snap_seg_q;
        snap_blank_d  = start ? live_blank : snap_blank_q;
        snap_bright_d = start ? live_bright : snap_bright_q;
        // The slot-start cycle drives outputs from the snapshot being taken, so bright=15 lights sub 0..14.
        lit     = sub_q < snap_bright_d && !snap_blank_d;
        dig_d   = lit ? DIG_OFF ^ (DIGITS'(1) << idx_q) : DIG_OFF;
        seg_d   = lit ? SEG_OFF ^ snap_seg_d : SEG_OFF;
        frame_d = start && idx_q == '0;
    end

    always_ff @(posedge clk_sys or posedge rst) begin
        if (rst) begin
            pre_q         <= '0;
            sub_q         <= '0;
            idx_q         <= '0;
            snap_seg_q    <= '0;
            snap_blank_q  <= 1'b0;
            snap_bright_q <= '0;
            dig_q         <= DIG_OFF;
            seg_q         <= SEG_OFF;
            frame_q       <= 1'b0;
        end else begin
            pre_q         <= pre_d;
            sub_q         <= sub_d;
            idx_q         <= idx_d;
            snap_seg_q    <= snap_seg_d;
            snap_blank_q  <= snap_blank_d;
            snap_bright_q <= snap_bright_d;
            dig_q         <= dig_d;
            seg_q         <= seg_d;
            frame_q       <= frame_d;
        end
    end

    assign dig   = dig_q;
    assign seg   = seg_q;
    assign frame = frame_q;
endmodule
